// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one single-ported data memory between a load
// requester and a store requester. Each requester owns a one-deep pending
// slot. At most one slot issues per cycle: a store goes first when both slots
// target the same word, otherwise grants alternate between requesters.
//
// Ports
//   clk_i, rst_i                     clock, synchronous active-high reset
//   ld_req_i, ld_addr_i              load request pulse and byte address
//   ld_busy_o                        load slot cannot accept a request now
//   ld_valid_o, ld_data_o            one-cycle load completion and word
//   st_req_i, st_addr_i, st_data_i,
//   st_width_i                       store request (0 byte, 1 half, 2 word, 3 none)
//   st_busy_o, st_done_o             store slot full, one-cycle store commit
//   mem_en_o, mem_we_o, mem_addr_o,
//   mem_be_o, mem_wdata_o            memory port, driven from slot state
//   mem_rdata_i                      read data, one cycle after a read issue
//   overflow_o                       sticky: a request hit a busy slot
module memory_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ld_req_i,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  output logic                  ld_busy_o,
  output logic                  ld_valid_o,
  output logic [31:0]           ld_data_o,
  input  logic                  st_req_i,
  input  logic [ADDR_WIDTH-1:0] st_addr_i,
  input  logic [31:0]           st_data_i,
  input  logic [1:0]            st_width_i,
  output logic                  st_busy_o,
  output logic                  st_done_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-3:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  output logic                  overflow_o
);

  localparam int unsigned WORD_AW = ADDR_WIDTH - 2;

  typedef enum logic {
    GRANT_LD = 1'b0,
    GRANT_ST = 1'b1
  } grant_e;

  // Load slot keeps only the word address; loads always read the full word.
  logic               ld_v_q;
  logic [WORD_AW-1:0] ld_waddr_q;
  logic               st_v_q;
  logic [ADDR_WIDTH-1:0] st_addr_q;
  logic [31:0]        st_data_q;
  logic [1:0]         st_width_q;
  grant_e             last_grant_q;
  logic               ld_pend_q;
  logic               st_pend_q;
  logic               overflow_q;

  logic               issue_ld;
  logic               issue_st;
  logic               same_word;
  logic [3:0]         st_be;
  logic               ld_addr_lo_unused;

  assign ld_addr_lo_unused = ^ld_addr_i[1:0];

  assign same_word = (ld_waddr_q == st_addr_q[ADDR_WIDTH-1:2]);

  // Grant selection; nothing issues while reset is held.
  always_comb begin
    issue_ld = 1'b0;
    issue_st = 1'b0;
    if (!rst_i) begin
      if (ld_v_q && st_v_q) begin
        // Same word: store first so the load observes the new data.
        if (same_word || (last_grant_q == GRANT_LD)) issue_st = 1'b1;
        else                                         issue_ld = 1'b1;
      end else if (ld_v_q) begin
        issue_ld = 1'b1;
      end else if (st_v_q) begin
        issue_st = 1'b1;
      end
    end
  end

  // A slot being issued this cycle frees up for a same-cycle request.
  assign ld_busy_o = ld_v_q && !issue_ld;
  assign st_busy_o = st_v_q && !issue_st;

  // Store byte enables; the reserved width writes no bytes but still completes.
  always_comb begin
    st_be = 4'h0;
    case (st_width_q)
      2'd0:    st_be = 4'b0001 << st_addr_q[1:0];
      2'd1:    st_be = 4'b0011 << {st_addr_q[1], 1'b0};
      2'd2:    st_be = 4'hF;
      default: st_be = 4'h0;
    endcase
  end

  // Memory port driven straight from the granted slot.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = 4'h0;
    mem_wdata_o = 32'h0;
    if (issue_st) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = st_addr_q[ADDR_WIDTH-1:2];
      mem_be_o    = st_be;
      mem_wdata_o = st_data_q;
    end else if (issue_ld) begin
      mem_en_o    = 1'b1;
      mem_addr_o  = ld_waddr_q;
      mem_be_o    = 4'hF;
    end
  end

  // Slot, grant history, completion and overflow state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ld_v_q       <= 1'b0;
      ld_waddr_q   <= '0;
      st_v_q       <= 1'b0;
      st_addr_q    <= '0;
      st_data_q    <= 32'h0;
      st_width_q   <= 2'd0;
      last_grant_q <= GRANT_ST;
      ld_pend_q    <= 1'b0;
      st_pend_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (ld_req_i && !ld_busy_o) begin
        ld_v_q     <= 1'b1;
        ld_waddr_q <= ld_addr_i[ADDR_WIDTH-1:2];
      end else if (issue_ld) begin
        ld_v_q     <= 1'b0;
      end

      if (st_req_i && !st_busy_o) begin
        st_v_q     <= 1'b1;
        st_addr_q  <= st_addr_i;
        st_data_q  <= st_data_i;
        st_width_q <= st_width_i;
      end else if (issue_st) begin
        st_v_q     <= 1'b0;
      end

      if (issue_ld || issue_st) last_grant_q <= issue_st ? GRANT_ST : GRANT_LD;

      ld_pend_q <= issue_ld;
      st_pend_q <= issue_st;

      if ((ld_req_i && ld_busy_o) || (st_req_i && st_busy_o)) overflow_q <= 1'b1;
    end
  end

  // Completions are masked while reset is held so in-flight work never reports.
  assign ld_valid_o = ld_pend_q && !rst_i;
  assign st_done_o  = st_pend_q && !rst_i;
  assign ld_data_o  = ld_valid_o ? mem_rdata_i : 32'h0;
  assign overflow_o = overflow_q;

endmodule
